// File: rtl/poly_tone_gen.sv
// poly_tone_gen: polyphonic buzzer driver. Up to NUM_VOICES pressed keys get
// their own half-period counters; the speaker plays the lowest key or rotates.
// Ports: clk, rst (async high), stop (pause), mode (0 mono / 1 rotate),
//   note[6:0] keys, pitch[2:0] one-hot octave, speaker (square wave),
//   sel (buzzer enable, tied 1), markLED (registered note), voice_count.
module poly_tone_gen #(
  parameter int NUM_VOICES   = 3,
  parameter int CNT_W        = 32,
  parameter int SLICE_CYCLES = 100000,
  parameter int SIM_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic       mode,
  input  logic [6:0] note,
  input  logic [2:0] pitch,
  output logic       speaker,
  output logic       sel,
  output logic [6:0] markLED,
  output logic [2:0] voice_count
);

  localparam int NV = NUM_VOICES;
  localparam logic [2:0] NV3 = 3'(NUM_VOICES);
  localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(SLICE_CYCLES - 1);

  logic [6:0]       note_q;
  logic [2:0]       pitch_q;
  logic [2:0]       pitch_prev;
  logic [CNT_W-1:0] cnt [NV];
  logic [NV-1:0]    phase;
  logic [2:0]       key_idx [NV];
  logic [2:0]       idx_prev [NV];
  logic [NV-1:0]    act;
  logic [NV-1:0]    act_prev;
  logic [NV-1:0]    retrig;
  logic [CNT_W-1:0] half [NV];
  logic [CNT_W-1:0] slice_cnt;
  logic [2:0]       sel_idx;
  logic             oct_ok;
  logic [3:0]       n_set;
  logic [31:0]      base_v;
  logic [31:0]      oct_v;

  function automatic logic [31:0] base_of(input logic [2:0] k);
    case (k)
      3'd0:    return 32'd191112;
      3'd1:    return 32'd170068;
      3'd2:    return 32'd151515;
      3'd3:    return 32'd142857;
      3'd4:    return 32'd127551;
      3'd5:    return 32'd113636;
      default: return 32'd101215;
    endcase
  endfunction

  assign sel     = 1'b1;
  assign markLED = note_q;

  // Voice v takes the (v+1)-th set key counting up from bit 0.
  always_comb begin
    oct_ok = (pitch_q == 3'b001) || (pitch_q == 3'b010) ||
             (pitch_q == 3'b100);
    n_set = '0;
    act   = '0;
    for (int v = 0; v < NV; v++) key_idx[v] = '0;
    for (int b = 0; b < 7; b++) begin
      if (note_q[b]) begin
        for (int v = 0; v < NV; v++) begin
          if (n_set == 4'(v)) begin
            key_idx[v] = 3'(b);
            act[v]     = oct_ok;
          end
        end
        n_set = n_set + 4'd1;
      end
    end
    if (!oct_ok)
      voice_count = 3'd0;
    else if (n_set > {1'b0, NV3})
      voice_count = NV3;
    else
      voice_count = n_set[2:0];
  end

  always_comb begin
    base_v = '0;
    oct_v  = '0;
    for (int v = 0; v < NV; v++) begin
      base_v = base_of(key_idx[v]);
      if (pitch_q[0])
        oct_v = base_v << 1;
      else if (pitch_q[2])
        oct_v = base_v >> 1;
      else
        oct_v = base_v;
      half[v] = CNT_W'(oct_v >> SIM_SHIFT);
    end
  end

  // A voice restarts when its key, its active flag or the octave moves.
  always_comb begin
    for (int v = 0; v < NV; v++)
      retrig[v] = (key_idx[v] != idx_prev[v]) ||
                  (act[v] != act_prev[v]) ||
                  (pitch_q != pitch_prev);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q     <= '0;
      pitch_q    <= '0;
      pitch_prev <= '0;
      act_prev   <= '0;
      phase      <= '0;
      slice_cnt  <= '0;
      sel_idx    <= '0;
      speaker    <= 1'b0;
      for (int v = 0; v < NV; v++) begin
        cnt[v]      <= '0;
        idx_prev[v] <= '0;
      end
    end else begin
      note_q  <= note;
      pitch_q <= pitch;
      // History only advances while running, so a change seen
      // during stop still retriggers once stop drops.
      if (!stop) begin
        pitch_prev <= pitch_q;
        act_prev   <= act;
        for (int v = 0; v < NV; v++) begin
          idx_prev[v] <= key_idx[v];
          if (retrig[v] || !act[v]) begin
            cnt[v]   <= '0;
            phase[v] <= 1'b0;
          end else if (cnt[v] == half[v] - 1'b1) begin
            cnt[v]   <= '0;
            phase[v] <= ~phase[v];
          end else begin
            cnt[v] <= cnt[v] + 1'b1;
          end
        end
        if (!mode) begin
          slice_cnt <= '0;
          speaker   <= (voice_count != 3'd0) & phase[0];
        end else if (sel_idx >= voice_count) begin
          slice_cnt <= '0;
          sel_idx   <= '0;
          speaker   <= 1'b0;
        end else begin
          speaker <= phase[sel_idx];
          if (slice_cnt == SLICE_LAST) begin
            slice_cnt <= '0;
            if (sel_idx + 3'd1 == voice_count)
              sel_idx <= '0;
            else
              sel_idx <= sel_idx + 3'd1;
          end else begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// tb_poly_tone_gen: scoreboard bench for poly_tone_gen with a time-based
// tone model (elapsed counts / half-period) and randomized key/octave play.
module tb_poly_tone_gen;

  localparam int NV = 3;
  localparam int SC = 300;
  localparam int SH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       stop;
  logic       mode;
  logic [6:0] note;
  logic [2:0] pitch;
  logic       speaker;
  logic       sel;
  logic [6:0] markLED;
  logic [2:0] voice_count;

  always #5 clk = ~clk;

  poly_tone_gen #(
    .NUM_VOICES(NV), .CNT_W(32), .SLICE_CYCLES(SC), .SIM_SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .stop(stop), .mode(mode), .note(note),
    .pitch(pitch), .speaker(speaker), .sel(sel), .markLED(markLED),
    .voice_count(voice_count)
  );

  typedef struct {
    logic       spk;
    logic [6:0] led;
    logic [2:0] vc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp,
               $time);
    end
  endtask

  function automatic int half_of(input int k, input logic [2:0] p);
    int base [7] = '{191112, 170068, 151515, 142857, 127551, 113636, 101215};
    int b;
    b = base[k];
    if (p == 3'b001) b = b * 2;
    else if (p == 3'b100) b = b / 2;
    return b >> SH;
  endfunction

  function automatic int vc_of(input logic [6:0] n, input logic [2:0] p);
    int c;
    if (!$onehot(p)) return 0;
    c = $countones(n);
    return (c > NV) ? NV : c;
  endfunction

  // Reference model: a voice's phase is floor(elapsed/L) mod 2, where
  // elapsed counts running cycles since its last (re)start.
  logic [6:0] m_note;
  logic [2:0] m_pitch;
  logic [2:0] m_ppitch;
  int  e [NV];
  int  lrun [NV];
  int  pk [NV];
  bit  pa [NV];
  bit  ph [NV];
  int  m_slice;
  int  m_sidx;
  bit  m_spk;
  int  ks[$];
  exp_t x;

  always @(posedge clk) begin
    if (rst) begin
      m_note = '0; m_pitch = '0; m_ppitch = '0;
      m_slice = 0; m_sidx = 0; m_spk = 0;
      for (int v = 0; v < NV; v++) begin
        e[v] = 0; lrun[v] = 1; pk[v] = 0; pa[v] = 0;
      end
    end else begin
      int vc;
      bit valid;
      valid = $onehot(m_pitch);
      ks.delete();
      for (int b = 0; b < 7; b++)
        if (m_note[b] && ks.size() < NV) ks.push_back(b);
      vc = vc_of(m_note, m_pitch);
      for (int v = 0; v < NV; v++) ph[v] = ((e[v] / lrun[v]) % 2) != 0;
      if (!stop) begin
        if (!mode) begin
          m_slice = 0;
          m_spk = (vc > 0) ? ph[0] : 1'b0;
        end else if (m_sidx >= vc) begin
          m_sidx = 0; m_slice = 0; m_spk = 0;
        end else begin
          m_spk = ph[m_sidx];
          if (m_slice == SC - 1) begin
            m_slice = 0;
            m_sidx = (m_sidx + 1) % vc;
          end else m_slice++;
        end
        for (int v = 0; v < NV; v++) begin
          bit a;
          int k;
          int l;
          bit rt;
          a = valid && (v < ks.size());
          k = (v < ks.size()) ? ks[v] : 0;
          l = half_of(k, m_pitch);
          rt = (a != pa[v]) || (a && k != pk[v]) || (m_pitch != m_ppitch);
          if (rt || !a) e[v] = 0;
          else e[v]++;
          lrun[v] = (l > 0) ? l : 1;
          pa[v] = a;
          pk[v] = k;
        end
        m_ppitch = m_pitch;
      end
      m_note = note;
      m_pitch = pitch;
    end
    x.spk = m_spk;
    x.led = m_note;
    x.vc  = 3'(vc_of(m_note, m_pitch));
    q.push_back(x);
  end

  // Monitor: one expected bundle per clock, compared just after the edge.
  always @(posedge clk) begin
    exp_t y;
    #1;
    if (q.size() > 0) begin
      y = q.pop_front();
      chk("speaker", 32'(speaker), 32'(y.spk));
      chk("markLED", 32'(markLED), 32'(y.led));
      chk("voice_count", 32'(voice_count), 32'(y.vc));
      chk("sel", 32'(sel), 32'd1);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1; stop = 1'b0; mode = 1'b0; note = '0; pitch = 3'b010;
    run(3);
    chk("reset_speaker", 32'(speaker), 32'd0);
    chk("reset_vc", 32'(voice_count), 32'd0);
    rst = 1'b0;
    run(5);

    // Press do: first rising edge lands L+2 edges after capture.
    note = 7'b0000001;
    @(posedge clk);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!speaker && k < 5000);
    chk("press_latency", 32'(k), 32'(746 + 2));

    @(negedge clk);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (speaker && k < 5000);
    chk("mid_do_half", 32'(k), 32'd746);
    run(2000);

    pitch = 3'b001; run(2000);
    pitch = 3'b100; run(1000);

    pitch = 3'b010; mode = 1'b1; note = 7'b1010001;
    run(3 * SC * 3);

    note = 7'b1111111;
    k = 0;
    run(5);
    while (m_sidx != 2 && k < 4 * SC) begin
      @(negedge clk); k++;
    end
    chk("reach_sidx2", 32'(m_sidx), 32'd2);
    note = 7'b0000100;
    run(2000);

    run(300);
    stop = 1'b1; run(500);
    stop = 1'b0; run(1000);

    mode = 1'b0;
    note = 7'b0100110; pitch = 3'b011; run(200);
    pitch = 3'b010; run(1200);

    k = 0;
    while (!speaker && k < 3000) begin
      @(negedge clk); k++;
    end
    chk("tone_before_rst", 32'(speaker), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_speaker", 32'(speaker), 32'd0);
    chk("async_rst_led", 32'(markLED), 32'd0);
    chk("async_rst_vc", 32'(voice_count), 32'd0);
    chk("async_rst_sel", 32'(sel), 32'd1);
    run(2);
    rst = 1'b0;
    run(3);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] p;
      note = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) note = '0;
      case ($urandom_range(0, 7))
        0: p = 3'($urandom_range(0, 7));
        1, 2: p = 3'b001;
        3, 4, 5: p = 3'b010;
        default: p = 3'b100;
      endcase
      pitch = p;
      mode = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) == 0);
      run($urandom_range(100, 800));
      if (stop) begin
        stop = 1'b0;
        run($urandom_range(100, 600));
      end
    end

    run(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
